// File: rtl/automaton_step_sequencer_if.sv
// Control/status bundle between the step sequencer and its user, divider and grid engine.
// Signal directions are named from the sequencer's point of view.
interface automaton_step_sequencer_if #(
  parameter int GEN_W = 16
);
  logic             i_run;
  logic             i_step;
  logic             i_rate_up;
  logic             i_rate_down;
  logic             i_clear_stats;
  logic             i_tick;
  logic             i_update_done;
  logic             o_div_en;
  logic [1:0]       o_rate_select;
  logic             o_update_start;
  logic             o_busy;
  logic [GEN_W-1:0] o_gen_count;
  logic             o_overrun;
  logic             o_fault;

  modport slave (
    input  i_run, i_step, i_rate_up, i_rate_down, i_clear_stats, i_tick, i_update_done,
    output o_div_en, o_rate_select, o_update_start, o_busy, o_gen_count, o_overrun, o_fault
  );

  modport master (
    output i_run, i_step, i_rate_up, i_rate_down, i_clear_stats, i_tick, i_update_done,
    input  o_div_en, o_rate_select, o_update_start, o_busy, o_gen_count, o_overrun, o_fault
  );
endinterface

// File: rtl/automaton_step_sequencer.sv
// Turns divider ticks or single-step requests into grid-engine update pulses,
// counts completed generations and flags dropped ticks and hung updates.
//
//  state     | meaning
//  ----------+---------------------------------------------------------
//  IDLE      | paused, divider disabled, waiting for step or run
//  WAIT_TICK | free-running, divider enabled, waiting for tick or step
//  START     | update_start pulse to the engine, timeout counter cleared
//  UPDATING  | waiting for update_done, timeout counter running
module automaton_step_sequencer #(
  parameter int GEN_W       = 16,
  parameter int TIMEOUT_CYC = 1024,
  parameter int INIT_RATE   = 2
) (
  input  logic                           clk,
  input  logic                           reset_n,
  automaton_step_sequencer_if.slave      bus
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TICK = 2'd1,
    START     = 2'd2,
    UPDATING  = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [GEN_W-1:0] r_gen;
  logic [1:0]       r_rate;
  logic             r_div_en;
  logic             r_update_start;
  logic             r_busy;
  logic             r_overrun;
  logic             r_fault;

  logic w_in_update;
  assign w_in_update = (r_state == START) || (r_state == UPDATING);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_gen          <= '0;
      r_rate         <= 2'(INIT_RATE);
      r_div_en       <= 1'b0;
      r_update_start <= 1'b0;
      r_busy         <= 1'b0;
      r_overrun      <= 1'b0;
      r_fault        <= 1'b0;
    end else begin
      r_update_start <= 1'b0;

      // Output registers are loaded together with the state they belong to.
      case (r_state)
        IDLE: begin
          if (bus.i_step) begin
            r_state        <= START;
            r_update_start <= 1'b1;
            r_busy         <= 1'b1;
            r_cnt          <= '0;
          end else if (bus.i_run) begin
            r_state  <= WAIT_TICK;
            r_div_en <= 1'b1;
          end
        end
        WAIT_TICK: begin
          if (bus.i_step || bus.i_tick) begin
            r_state        <= START;
            r_update_start <= 1'b1;
            r_busy         <= 1'b1;
            r_div_en       <= 1'b0;
            r_cnt          <= '0;
          end else if (!bus.i_run) begin
            r_state  <= IDLE;
            r_div_en <= 1'b0;
          end
        end
        START: begin
          r_state <= UPDATING;
        end
        UPDATING: begin
          if (bus.i_update_done) begin
            r_gen  <= r_gen + GEN_W'(1);
            r_busy <= 1'b0;
            if (bus.i_run) begin
              r_state  <= WAIT_TICK;
              r_div_en <= 1'b1;
            end else begin
              r_state <= IDLE;
            end
          end else if (r_cnt == CNT_LAST) begin
            r_fault <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state  <= IDLE;
          r_div_en <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase

      if (w_in_update && bus.i_tick) begin
        r_overrun <= 1'b1;
      end

      // Placed after the set paths so a same-cycle clear wins.
      if (bus.i_clear_stats) begin
        r_gen     <= '0;
        r_overrun <= 1'b0;
        r_fault   <= 1'b0;
      end

      if (bus.i_rate_up && !bus.i_rate_down && (r_rate != 2'd3)) begin
        r_rate <= r_rate + 2'd1;
      end else if (bus.i_rate_down && !bus.i_rate_up && (r_rate > 2'd1)) begin
        r_rate <= r_rate - 2'd1;
      end
    end
  end

  assign bus.o_div_en       = r_div_en;
  assign bus.o_rate_select  = r_rate;
  assign bus.o_update_start = r_update_start;
  assign bus.o_busy         = r_busy;
  assign bus.o_gen_count    = r_gen;
  assign bus.o_overrun      = r_overrun;
  assign bus.o_fault        = r_fault;

endmodule

// File: tb/tb_automaton_step_sequencer.sv
// Bench for automaton_step_sequencer: update_start timing is scoreboarded against
// expected cycles queued when step/tick stimulus is driven; status is checked inline.
module tb_automaton_step_sequencer;

  localparam int GEN_W       = 4;
  localparam int TIMEOUT_CYC = 16;
  localparam int INIT_RATE   = 2;

  logic clk;
  logic reset_n;
  int   cyc;
  int   checks;
  int   errors;
  int   exp_q[$];

  automaton_step_sequencer_if #(.GEN_W(GEN_W)) s ();

  automaton_step_sequencer #(
    .GEN_W(GEN_W), .TIMEOUT_CYC(TIMEOUT_CYC), .INIT_RATE(INIT_RATE)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(s.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Scoreboard: every update_start must match the oldest queued expected cycle.
  always @(negedge clk) begin
    if (reset_n) begin
      if (s.o_update_start) begin
        checks = checks + 1;
        if (exp_q.size() == 0) begin
          errors = errors + 1;
          $display("FAIL start_unexpected: update_start at cycle %0d, none expected", cyc);
        end else begin
          int e;
          e = exp_q.pop_front();
          if (e !== cyc) begin
            errors = errors + 1;
            $display("FAIL start_cycle: update_start at cycle %0d, expected cycle %0d", cyc, e);
          end
        end
      end else if (exp_q.size() > 0 && exp_q[0] < cyc) begin
        int e;
        checks = checks + 1;
        errors = errors + 1;
        e = exp_q.pop_front();
        $display("FAIL start_missing: no update_start by cycle %0d, expected at %0d", cyc, e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_step(input bit expect_start);
    nxt();
    s.i_step = 1'b1;
    if (expect_start) exp_q.push_back(cyc + 1);
    nxt();
    s.i_step = 1'b0;
  endtask

  task automatic pulse_tick(input bit expect_start);
    nxt();
    s.i_tick = 1'b1;
    if (expect_start) exp_q.push_back(cyc + 1);
    nxt();
    s.i_tick = 1'b0;
  endtask

  task automatic pulse_done_after(input int n);
    repeat (n) nxt();
    s.i_update_done = 1'b1;
    nxt();
    s.i_update_done = 1'b0;
  endtask

  task automatic pulse_clear();
    s.i_clear_stats = 1'b1;
    nxt();
    s.i_clear_stats = 1'b0;
  endtask

  task automatic pulse_rate(input bit up, input bit down);
    s.i_rate_up   = up;
    s.i_rate_down = down;
    nxt();
    s.i_rate_up   = 1'b0;
    s.i_rate_down = 1'b0;
  endtask

  task automatic test_reset();
    checks = checks + 7;
    if (s.o_rate_select !== 2'd2) begin errors++; $display("FAIL reset_rate: got %0d want 2", s.o_rate_select); end
    if (s.o_div_en !== 1'b0) begin errors++; $display("FAIL reset_div_en: got %b want 0", s.o_div_en); end
    if (s.o_update_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", s.o_update_start); end
    if (s.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", s.o_busy); end
    if (s.o_gen_count !== 4'd0) begin errors++; $display("FAIL reset_gen: got %0d want 0", s.o_gen_count); end
    if (s.o_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", s.o_overrun); end
    if (s.o_fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b want 0", s.o_fault); end
  endtask

  task automatic test_single_step();
    pulse_step(1'b1);
    checks++;
    if (s.o_busy !== 1'b1) begin errors++; $display("FAIL step_busy: got %b want 1", s.o_busy); end
    pulse_done_after(5);
    checks = checks + 3;
    if (s.o_gen_count !== 4'd1) begin errors++; $display("FAIL step_gen: got %0d want 1", s.o_gen_count); end
    if (s.o_busy !== 1'b0) begin errors++; $display("FAIL step_idle_busy: got %b want 0", s.o_busy); end
    if (s.o_div_en !== 1'b0) begin errors++; $display("FAIL step_idle_div_en: got %b want 0", s.o_div_en); end
  endtask

  task automatic test_free_run();
    pulse_clear();
    s.i_run = 1'b1;
    nxt();
    checks++;
    if (s.o_div_en !== 1'b1) begin errors++; $display("FAIL run_div_en: got %b want 1", s.o_div_en); end
    for (int i = 0; i < 4; i++) begin
      pulse_tick(1'b1);
      pulse_done_after(3);
      checks = checks + 2;
      if (s.o_div_en !== 1'b1) begin errors++; $display("FAIL run_wait_div_en[%0d]: got %b want 1", i, s.o_div_en); end
      if (s.o_busy !== 1'b0) begin errors++; $display("FAIL run_wait_busy[%0d]: got %b want 0", i, s.o_busy); end
      repeat (2) nxt();
    end
    checks++;
    if (s.o_gen_count !== 4'd4) begin errors++; $display("FAIL run_gen: got %0d want 4", s.o_gen_count); end
    s.i_run = 1'b0;
    nxt();
    checks++;
    if (s.o_div_en !== 1'b0) begin errors++; $display("FAIL pause_div_en: got %b want 0", s.o_div_en); end
  endtask

  task automatic test_overrun();
    pulse_step(1'b1);
    nxt();
    s.i_tick = 1'b1;
    nxt();
    s.i_tick = 1'b0;
    checks++;
    if (s.o_overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b want 1", s.o_overrun); end
    pulse_step(1'b0);
    pulse_done_after(0);
    checks = checks + 2;
    if (s.o_gen_count !== 4'd5) begin errors++; $display("FAIL overrun_gen: got %0d want 5", s.o_gen_count); end
    if (s.o_overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b want 1", s.o_overrun); end
    pulse_clear();
    checks = checks + 2;
    if (s.o_overrun !== 1'b0) begin errors++; $display("FAIL clear_overrun: got %b want 0", s.o_overrun); end
    if (s.o_gen_count !== 4'd0) begin errors++; $display("FAIL clear_gen: got %0d want 0", s.o_gen_count); end
    pulse_step(1'b1);
    nxt();
    s.i_update_done = 1'b1;
    s.i_clear_stats = 1'b1;
    nxt();
    s.i_update_done = 1'b0;
    s.i_clear_stats = 1'b0;
    checks = checks + 2;
    if (s.o_gen_count !== 4'd0) begin errors++; $display("FAIL clear_wins_gen: got %0d want 0", s.o_gen_count); end
    if (s.o_busy !== 1'b0) begin errors++; $display("FAIL clear_wins_busy: got %b want 0", s.o_busy); end
  endtask

  task automatic test_timeout();
    pulse_step(1'b1);
    repeat (TIMEOUT_CYC) nxt();
    checks = checks + 2;
    if (s.o_busy !== 1'b1) begin errors++; $display("FAIL timeout_busy_last: got %b want 1", s.o_busy); end
    if (s.o_fault !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b want 0", s.o_fault); end
    nxt();
    checks = checks + 3;
    if (s.o_fault !== 1'b1) begin errors++; $display("FAIL timeout_fault: got %b want 1", s.o_fault); end
    if (s.o_busy !== 1'b0) begin errors++; $display("FAIL timeout_idle: got %b want 0", s.o_busy); end
    if (s.o_gen_count !== 4'd0) begin errors++; $display("FAIL timeout_gen: got %0d want 0", s.o_gen_count); end
    pulse_done_after(0);
    checks++;
    if (s.o_gen_count !== 4'd0) begin errors++; $display("FAIL late_done_gen: got %0d want 0", s.o_gen_count); end
    pulse_step(1'b1);
    pulse_done_after(2);
    checks = checks + 2;
    if (s.o_gen_count !== 4'd1) begin errors++; $display("FAIL after_fault_gen: got %0d want 1", s.o_gen_count); end
    if (s.o_fault !== 1'b1) begin errors++; $display("FAIL fault_sticky: got %b want 1", s.o_fault); end
    pulse_clear();
    checks++;
    if (s.o_fault !== 1'b0) begin errors++; $display("FAIL clear_fault: got %b want 0", s.o_fault); end
  endtask

  task automatic test_rate();
    repeat (3) pulse_rate(1'b1, 1'b0);
    checks++;
    if (s.o_rate_select !== 2'd3) begin errors++; $display("FAIL rate_sat_hi: got %0d want 3", s.o_rate_select); end
    repeat (4) pulse_rate(1'b0, 1'b1);
    checks++;
    if (s.o_rate_select !== 2'd1) begin errors++; $display("FAIL rate_sat_lo: got %0d want 1", s.o_rate_select); end
    pulse_rate(1'b1, 1'b0);
    checks++;
    if (s.o_rate_select !== 2'd2) begin errors++; $display("FAIL rate_up: got %0d want 2", s.o_rate_select); end
    pulse_rate(1'b1, 1'b1);
    checks++;
    if (s.o_rate_select !== 2'd2) begin errors++; $display("FAIL rate_both: got %0d want 2", s.o_rate_select); end
  endtask

  task automatic test_back_to_back_wrap();
    pulse_clear();
    for (int i = 1; i <= 16; i++) begin
      pulse_step(1'b1);
      pulse_done_after(1);
      if (i == 15) begin
        checks++;
        if (s.o_gen_count !== 4'd15) begin errors++; $display("FAIL wrap_pre: got %0d want 15", s.o_gen_count); end
      end
    end
    checks++;
    if (s.o_gen_count !== 4'd0) begin errors++; $display("FAIL wrap_zero: got %0d want 0", s.o_gen_count); end
    pulse_rate(1'b1, 1'b0);
    s.i_tick = 1'b0;
    pulse_step(1'b1);
    s.i_tick = 1'b1;
    nxt();
    s.i_tick = 1'b0;
    pulse_done_after(0);
    pulse_step(1'b1);
    nxt();
    reset_n = 1'b0;
    #1;
    checks = checks + 7;
    if (s.o_update_start !== 1'b0) begin errors++; $display("FAIL rst_mid_start: got %b want 0", s.o_update_start); end
    if (s.o_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", s.o_busy); end
    if (s.o_div_en !== 1'b0) begin errors++; $display("FAIL rst_mid_div_en: got %b want 0", s.o_div_en); end
    if (s.o_gen_count !== 4'd0) begin errors++; $display("FAIL rst_mid_gen: got %0d want 0", s.o_gen_count); end
    if (s.o_overrun !== 1'b0) begin errors++; $display("FAIL rst_mid_overrun: got %b want 0", s.o_overrun); end
    if (s.o_fault !== 1'b0) begin errors++; $display("FAIL rst_mid_fault: got %b want 0", s.o_fault); end
    if (s.o_rate_select !== 2'd2) begin errors++; $display("FAIL rst_mid_rate: got %0d want 2", s.o_rate_select); end
    nxt();
    reset_n = 1'b1;
    nxt();
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    reset_n         = 1'b0;
    s.i_run         = 1'b0;
    s.i_step        = 1'b0;
    s.i_rate_up     = 1'b0;
    s.i_rate_down   = 1'b0;
    s.i_clear_stats = 1'b0;
    s.i_tick        = 1'b0;
    s.i_update_done = 1'b0;
    repeat (3) nxt();
    test_reset();
    reset_n = 1'b1;
    nxt();
    test_single_step();
    test_free_run();
    test_overrun();
    test_timeout();
    test_rate();
    test_back_to_back_wrap();
    repeat (3) nxt();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL start_queue_empty: %0d expected starts outstanding, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
